// File: rtl/serv_mem_if_par_if.sv
// Data-bus bundle between serv_mem_if_par (master) and the memory/interconnect (slave).
interface serv_mem_if_par_if;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic [31:0] i_wb_rdt;
   logic        i_wb_ack;
   logic        i_wb_err;

   modport master (
      output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
      input  i_wb_rdt, i_wb_ack, i_wb_err
   );

   modport slave (
      input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
      output i_wb_rdt, i_wb_ack, i_wb_err
   );
endinterface

// File: rtl/serv_mem_if_par.sv
// W-bit serial load/store unit: o_wb_cyc rises the cycle after the last init beat and holds until ack, err or timeout.
// The serial side never stalls; load data is replayed from the data register during the execute phase.
module serv_mem_if_par #(
   parameter int W       = 1,
   parameter int TIMEOUT = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_init,
   input  logic              i_cmd,
   input  logic [2:0]        i_funct3,
   input  logic [W-1:0]      i_rs1,
   input  logic [W-1:0]      i_rs2,
   input  logic [W-1:0]      i_imm,
   input  logic              i_trap,
   output logic [W-1:0]      o_rd,
   output logic              o_misalign,
   output logic              o_err,
   output logic              o_busy,
   serv_mem_if_par_if.master wb
);
   localparam int LW = $clog2(W);
   localparam int CW = 5 - LW;
   localparam int SW = 3 - LW;

   typedef enum logic [1:0] {IDLE, INIT, REQ, DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic          cyc_q, err_q, mis_q, sign_q;
   logic [7:0]    tmo_q;

   logic [W:0]    sum;
   logic          init_beat, init_last, exec, mis_d, tmo_hit, ld_ack;
   logic          is_word, is_half, valid;
   logic [1:0]    bytepos, byte_idx, lane;
   logic [SW-1:0] sub;
   logic [4:0]    bit_off;
   logic [W-1:0]  chunk;
   logic [3:0]    sel;

   assign is_word   = i_funct3[1];
   assign is_half   = (i_funct3[1:0] == 2'b01);
   assign init_beat = i_en & i_init;
   assign init_last = init_beat & (cnt_q == {CW{1'b1}});
   assign exec      = i_en & ~i_init;
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == 8'(TIMEOUT - 1));
   assign ld_ack    = cyc_q & wb.i_wb_ack & ~wb.i_wb_err & ~i_cmd;

   always_comb begin
      cnt_d   = i_en ? cnt_q + 1'b1 : '0;
      sum     = {1'b0, i_rs1} + {1'b0, i_imm} + {{W{1'b0}}, carry_q};
      carry_d = i_en & sum[W];
      adr_d   = adr_q;
      if (init_beat)
         adr_d = {sum[W-1:0], adr_q[31:W]};
      // At the last init beat adr_d already holds the complete address.
      mis_d = (is_half & adr_d[0]) | (is_word & (|adr_d[1:0]));
   end

   // One register carries store data out and load data back; an aborted or reset cycle never loads it.
   always_comb begin
      dat_d = dat_q;
      if (init_beat & i_cmd)
         dat_d = {i_rs2, dat_q[31:W]};
      else if (ld_ack & i_rst_n)
         dat_d = wb.i_wb_rdt;
   end

   assign bytepos  = adr_q[1:0];
   assign byte_idx = cnt_q[CW-1 -: 2];
   assign sub      = cnt_q[SW-1:0];
   assign lane     = bytepos + byte_idx;
   assign bit_off  = {lane, 3'b000} + (5'(sub) << LW);
   assign chunk    = W'(dat_q >> bit_off);
   assign valid    = is_word | (is_half & ~byte_idx[1]) | (byte_idx == 2'b00);

   always_comb begin
      o_rd = '0;
      if (exec)
         o_rd = valid ? chunk : {W{~i_funct3[2] & sign_q}};
   end

   always_comb begin
      if (is_word)
         sel = 4'b1111;
      else if (is_half)
         sel = {bytepos[1], bytepos[1], ~bytepos[1], ~bytepos[1]};
      else
         sel = 4'b0001 << bytepos;
   end

   assign wb.o_wb_adr = {adr_q[31:2], 2'b00};
   assign wb.o_wb_dat = is_word ? dat_q : is_half ? {2{dat_q[15:0]}} : {4{dat_q[7:0]}};
   assign wb.o_wb_sel = sel;
   assign wb.o_wb_we  = i_cmd;
   assign wb.o_wb_cyc = cyc_q;
   assign o_busy      = cyc_q;
   assign o_err       = err_q;
   assign o_misalign  = mis_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cyc_q   <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         sign_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         err_q   <= 1'b0;
         if (init_last)
            mis_q <= mis_d;
         if (exec & valid)
            sign_q <= chunk[W-1];
         case (state_q)
            IDLE: if (init_beat) state_q <= INIT;
            INIT: begin
               if (init_last) begin
                  if (!i_trap && !mis_d) begin
                     state_q <= REQ;
                     cyc_q   <= 1'b1;
                     tmo_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            REQ: begin
               tmo_q <= tmo_q + 8'd1;
               // Error beats a simultaneous ack; a late ack still beats the timeout.
               if (wb.i_wb_err) begin
                  state_q <= IDLE;
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
               end else if (wb.i_wb_ack) begin
                  state_q <= DONE;
                  cyc_q   <= 1'b0;
               end else if (tmo_hit) begin
                  state_q <= IDLE;
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
               end
            end
            DONE: if (init_beat) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      adr_q <= adr_d;
      dat_q <= dat_d;
   end
endmodule

// File: tb/tb_serv_mem_if_par.sv
// Self-checking bench: one DUT per lane width (1, 2, 4), table-driven accesses plus error/timeout/reset sequences.
module tb_serv_mem_if_par;
   typedef struct {
      int          w;
      logic        cmd;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [31:0] rs2;
      logic        trap;
      logic [31:0] rdt;
      logic        exp_cyc;
      logic        exp_mis;
      logic [31:0] exp_adr;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dat;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en1 = 1'b0, en2 = 1'b0, en4 = 1'b0;
   logic        init = 1'b0, cmd = 1'b0, trap = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] rs1_v = '0, rs2_v = '0, imm_v = '0, rdt = '0;
   logic        ack = 1'b0, err = 1'b0;
   logic [4:0]  beat = '0;
   int          cur_w = 1;
   int          checks = 0, errors = 0;
   vec_t        exp_q[$];

   logic        rs1_1, rs2_1, imm_1, rd1, mis1, err1, busy1;
   logic [1:0]  rs1_2, rs2_2, imm_2, rd2;
   logic        mis2, err2, busy2;
   logic [3:0]  rs1_4, rs2_4, imm_4, rd4;
   logic        mis4, err4, busy4;

   logic        m_cyc, m_we, m_mis, m_err, m_busy;
   logic [31:0] m_adr, m_dat;
   logic [3:0]  m_sel, m_rd;

   serv_mem_if_par_if if1 ();
   serv_mem_if_par_if if2 ();
   serv_mem_if_par_if if4 ();

   always #5 clk = ~clk;

   assign rs1_1 = rs1_v[beat +: 1];
   assign rs2_1 = rs2_v[beat +: 1];
   assign imm_1 = imm_v[beat +: 1];
   assign rs1_2 = rs1_v[{beat[3:0], 1'b0} +: 2];
   assign rs2_2 = rs2_v[{beat[3:0], 1'b0} +: 2];
   assign imm_2 = imm_v[{beat[3:0], 1'b0} +: 2];
   assign rs1_4 = rs1_v[{beat[2:0], 2'b00} +: 4];
   assign rs2_4 = rs2_v[{beat[2:0], 2'b00} +: 4];
   assign imm_4 = imm_v[{beat[2:0], 2'b00} +: 4];

   assign if1.i_wb_rdt = rdt;
   assign if1.i_wb_ack = ack;
   assign if1.i_wb_err = err;
   assign if2.i_wb_rdt = rdt;
   assign if2.i_wb_ack = ack;
   assign if2.i_wb_err = err;
   assign if4.i_wb_rdt = rdt;
   assign if4.i_wb_ack = ack;
   assign if4.i_wb_err = err;

   serv_mem_if_par #(.W(1), .TIMEOUT(8)) d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_init(init), .i_cmd(cmd), .i_funct3(funct3),
      .i_rs1(rs1_1), .i_rs2(rs2_1), .i_imm(imm_1), .i_trap(trap),
      .o_rd(rd1), .o_misalign(mis1), .o_err(err1), .o_busy(busy1), .wb(if1));
   serv_mem_if_par #(.W(2), .TIMEOUT(8)) d2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_init(init), .i_cmd(cmd), .i_funct3(funct3),
      .i_rs1(rs1_2), .i_rs2(rs2_2), .i_imm(imm_2), .i_trap(trap),
      .o_rd(rd2), .o_misalign(mis2), .o_err(err2), .o_busy(busy2), .wb(if2));
   serv_mem_if_par #(.W(4), .TIMEOUT(8)) d4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_init(init), .i_cmd(cmd), .i_funct3(funct3),
      .i_rs1(rs1_4), .i_rs2(rs2_4), .i_imm(imm_4), .i_trap(trap),
      .o_rd(rd4), .o_misalign(mis4), .o_err(err4), .o_busy(busy4), .wb(if4));

   always_comb begin
      m_cyc = if1.o_wb_cyc; m_adr = if1.o_wb_adr; m_sel = if1.o_wb_sel; m_dat = if1.o_wb_dat;
      m_we = if1.o_wb_we; m_rd = {3'b000, rd1}; m_mis = mis1; m_err = err1; m_busy = busy1;
      if (cur_w == 2) begin
         m_cyc = if2.o_wb_cyc; m_adr = if2.o_wb_adr; m_sel = if2.o_wb_sel; m_dat = if2.o_wb_dat;
         m_we = if2.o_wb_we; m_rd = {2'b00, rd2}; m_mis = mis2; m_err = err2; m_busy = busy2;
      end else if (cur_w == 4) begin
         m_cyc = if4.o_wb_cyc; m_adr = if4.o_wb_adr; m_sel = if4.o_wb_sel; m_dat = if4.o_wb_dat;
         m_we = if4.o_wb_we; m_rd = rd4; m_mis = mis4; m_err = err4; m_busy = busy4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic set_en(input logic v);
      en1 = v & (cur_w == 1);
      en2 = v & (cur_w == 2);
      en4 = v & (cur_w == 4);
   endtask

   // Drives one full serial phase on the selected DUT and gathers o_rd.
   task automatic run_phase(input logic ini, output logic [31:0] res);
      int n;
      n = 32 / cur_w;
      res = '0;
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         beat = 5'(b);
         init = ini;
         set_en(1'b1);
         #1;
         res = res | (32'(m_rd) << (b * cur_w));
      end
      @(negedge clk);
      set_en(1'b0);
      init = 1'b0;
      beat = '0;
   endtask

   task automatic setup(input vec_t v);
      cur_w = v.w; cmd = v.cmd; funct3 = v.f3; rs1_v = v.rs1; imm_v = v.imm;
      rs2_v = v.rs2; trap = v.trap;
   endtask

   task automatic do_vec(input vec_t v, input string tag);
      vec_t        e;
      logic [31:0] res;
      int          lat;
      setup(v);
      exp_q.push_back(v);
      run_phase(1'b1, res);
      #1;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         if (m_cyc) begin
            lat = k;
            break;
         end
         @(negedge clk);
         #1;
      end
      e = exp_q.pop_front();
      chk({tag, " cyc_seen"}, 32'(lat >= 0), 32'(e.exp_cyc));
      if (lat >= 0) begin
         chk({tag, " cyc_latency"}, 32'(lat), 32'd0);
         chk({tag, " busy"}, 32'(m_busy), 32'd1);
         chk({tag, " adr"}, m_adr, e.exp_adr);
         chk({tag, " sel"}, 32'(m_sel), 32'(e.exp_sel));
         chk({tag, " we"}, 32'(m_we), 32'(e.cmd));
         if (e.cmd) chk({tag, " dat"}, m_dat, e.exp_dat);
         repeat (2) @(negedge clk);
         ack = 1'b1;
         rdt = e.rdt;
         @(negedge clk);
         ack = 1'b0;
         #1;
         chk({tag, " cyc_drop"}, 32'(m_cyc), 32'd0);
         chk({tag, " no_err"}, 32'(m_err), 32'd0);
      end
      chk({tag, " misalign"}, 32'(m_mis), 32'(e.exp_mis));
      run_phase(1'b0, res);
      if (!e.cmd && e.exp_cyc) chk({tag, " rd"}, res, e.exp_rd);
   endtask

   vec_t        vt[14];
   vec_t        hv;
   logic [31:0] res;
   int          ncyc;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      //         w  cmd   f3      rs1           imm       rs2           trap  rdt           cyc   mis   adr           sel    dat           rd
      vt[0]  = '{1, 1'b0, 3'b010, 32'h0000_00F0, 32'h10, 32'h0,        1'b0, 32'h8000_00FF, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h8000_00FF};
      vt[1]  = '{4, 1'b0, 3'b000, 32'h0000_0100, 32'h3,  32'h0,        1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'h8, 32'h0,        32'hFFFF_FF80};
      vt[2]  = '{4, 1'b0, 3'b100, 32'h0000_0100, 32'h3,  32'h0,        1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'h8, 32'h0,        32'h0000_0080};
      vt[3]  = '{2, 1'b1, 3'b001, 32'h0000_0200, 32'h2,  32'h1234_ABCD, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0200, 4'hC, 32'hABCD_ABCD, 32'h0};
      vt[4]  = '{1, 1'b0, 3'b010, 32'h0000_0100, 32'h1,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
      vt[5]  = '{2, 1'b0, 3'b010, 32'h0000_0300, 32'h0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0};
      vt[6]  = '{1, 1'b0, 3'b001, 32'h0000_0100, 32'h2,  32'h0,        1'b0, 32'h8001_0000, 1'b1, 1'b0, 32'h0000_0100, 4'hC, 32'h0,        32'hFFFF_8001};
      vt[7]  = '{4, 1'b0, 3'b101, 32'h0000_0100, 32'h0,  32'h0,        1'b0, 32'h1234_F00F, 1'b1, 1'b0, 32'h0000_0100, 4'h3, 32'h0,        32'h0000_F00F};
      vt[8]  = '{1, 1'b1, 3'b000, 32'h0000_0003, 32'h4,  32'h0000_00A5, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0004, 4'h8, 32'hA5A5_A5A5, 32'h0};
      vt[9]  = '{2, 1'b0, 3'b010, 32'hFFFF_FFF0, 32'h14, 32'h0,        1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0,        32'h0BAD_F00D};
      vt[10] = '{2, 1'b0, 3'b000, 32'h0000_0200, 32'h1,  32'h0,        1'b0, 32'h0000_7F00, 1'b1, 1'b0, 32'h0000_0200, 4'h2, 32'h0,        32'h0000_007F};
      vt[11] = '{4, 1'b1, 3'b010, 32'h0000_1000, 32'h0,  32'hDEAD_BEEF, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0};
      vt[12] = '{4, 1'b0, 3'b010, 32'h0000_0200, 32'h2,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
      vt[13] = '{2, 1'b0, 3'b001, 32'h0000_0200, 32'h1,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};

      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         cur_w = (k == 0) ? 1 : (k == 1) ? 2 : 4;
         #1;
         chk($sformatf("reset_cyc_w%0d", cur_w), 32'(m_cyc), 32'd0);
         chk($sformatf("reset_busy_w%0d", cur_w), 32'(m_busy), 32'd0);
         chk($sformatf("reset_err_w%0d", cur_w), 32'(m_err), 32'd0);
         chk($sformatf("reset_mis_w%0d", cur_w), 32'(m_mis), 32'd0);
         chk($sformatf("reset_rd_w%0d", cur_w), 32'(m_rd), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++)
         do_vec(vt[i], $sformatf("vec%0d", i));

      // Simultaneous ack and err: error wins and the data register keeps the earlier load.
      hv = '{4, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 32'h1122_3344, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h1122_3344};
      do_vec(hv, "preload");
      setup(hv);
      run_phase(1'b1, res);
      #1;
      chk("errack_cyc_up", 32'(m_cyc), 32'd1);
      @(negedge clk);
      ack = 1'b1; err = 1'b1; rdt = 32'hFFFF_FFFF;
      @(negedge clk);
      ack = 1'b0; err = 1'b0;
      #1;
      chk("errack_cyc_drop", 32'(m_cyc), 32'd0);
      chk("errack_err_pulse", 32'(m_err), 32'd1);
      @(negedge clk);
      #1;
      chk("errack_err_one_cycle", 32'(m_err), 32'd0);
      run_phase(1'b0, res);
      chk("errack_data_kept", res, 32'h1122_3344);

      // No response at all: the bus cycle is abandoned after TIMEOUT cycles.
      setup(hv);
      run_phase(1'b1, res);
      #1;
      ncyc = 0;
      for (int k = 0; k < 50; k++) begin
         if (!m_cyc) break;
         ncyc++;
         @(negedge clk);
         #1;
      end
      chk("tmo_cyc_cycles", 32'(ncyc), 32'd8);
      chk("tmo_err_pulse", 32'(m_err), 32'd1);
      @(negedge clk);
      #1;
      chk("tmo_err_one_cycle", 32'(m_err), 32'd0);
      run_phase(1'b0, res);
      chk("tmo_data_kept", res, 32'h1122_3344);

      // Reset lands while the cycle is open, with an ack in the same cycle.
      hv = '{2, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0};
      setup(hv);
      run_phase(1'b1, res);
      #1;
      chk("rst_cyc_up", 32'(m_cyc), 32'd1);
      @(negedge clk);
      rst_n = 1'b0; ack = 1'b1; rdt = 32'hCAFE_F00D;
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("rst_cyc", 32'(m_cyc), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_err", 32'(m_err), 32'd0);
      chk("rst_mis", 32'(m_mis), 32'd0);
      chk("rst_rd", 32'(m_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_phase(1'b0, res);
      chk("rst_data_kept", res, 32'h0000_7F00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serv_mem_if_par.md
# serv_mem_if_par

Parametrised load/store unit for the SERV core: serialises the effective address and store data in, runs one Wisbone-style bus cycle, and serialises sign/zero-extended load data back out. It generalises the core's bit-serial memory interface to W bits per cycle (W = 1, 2, 4) and adds internal misalignment gating, bus-error input, and an ack timeout. It sits between the decoder/register-file datapath and the data bus.

## Interface
- W, 1, serial lanes per cycle; legal 1, 2, 4; one phase = 32/W cycles
- TIMEOUT, 0, cycles from o_wb_cyc rise to forced abort; 0 disables; max 255
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- i_en  in  1  serial phase active; high exactly 32/W consecutive cycles per phase
- i_init  in  1  high with i_en during the address/store-data phase
- i_cmd  in  1  1 store, 0 load
- i_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] 1 = unsigned load
- i_rs1, i_rs2, i_imm  in  W  serial operands, LSB-chunk first
- i_trap  in  1  suppress bus cycle for current access
- o_rd  out  W  serial load result; 0 when i_en low
- o_misalign  out  1  access misaligned; valid from cycle after init phase ends until next init phase
- o_err  out  1  one-cycle pulse: bus error or timeout
- o_busy  out  1  bus cycle outstanding
- o_wb_adr  out  32  word address; [1:0] = 0
- o_wb_dat  out  32  lane-replicated store data
- o_wb_sel  out  4  byte enables
- o_wb_we  out  1  = i_cmd
- o_wb_cyc  out  1  bus request
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  cycle complete
- i_wb_err  in  1  cycle failed

## Operation
- Beat counter cnt (5-log2(W) bits) increments while i_en, clears when i_en low; byte index = cnt·W/8.
- Address: W-bit serial adder rs1+imm, carry held between beats, carry cleared when i_en low; sum chunks shift into a 32-bit address register during init phase. bytepos = adr[1:0], captured from the first beat(s).
- misalign = (half & adr[0]) | (word & |adr[1:0]); latched at init end.
- Store data: byte replicated to all 4 lanes, half to both halves, word as-is; written only during init phase.
- o_wb_sel: word 1111; half {bp1,bp1,~bp1,~bp1}; byte 1<<bytepos.
- FSM IDLE→INIT (i_en & i_init)→REQ at init falling edge if !i_trap & !misalign, else IDLE. REQ: o_wb_cyc=1; exits to DONE on i_wb_ack, to IDLE with o_err on i_wb_err or timeout. DONE→IDLE on next init phase.
- On ack with !i_cmd, i_wb_rdt loads the data register. Execute phase (i_en & !i_init): o_rd emits bytes from lane (bytepos + byte index) while byte index < size in bytes; beyond that outputs sign-bit replicated (signed) or 0 (unsigned). Sign bit tracks last valid MSB emitted.
- Errors/aborts leave the data register unchanged.

## Timing
- Reset: o_wb_cyc, o_err, o_busy, o_misalign 0; FSM IDLE; cnt 0; carry 0.
- o_wb_cyc rises the cycle after the last init beat; o_busy = o_wb_cyc.
- ack sampled cycle N → o_wb_cyc low at N+1, data valid at N+1.
- ack & err same cycle: err wins, no load, o_err at N+1.
- ack/err with o_wb_cyc low: ignored.
- Timeout: counter starts at cyc rise; at TIMEOUT cycles without ack/err, cyc drops next cycle, o_err pulses.
- Reset asserted mid-cycle: o_wb_cyc low at next edge; any ack in that cycle ignored.
- i_init re-asserted while REQ: illegal; bench must not drive it.

## Test plan
- W=1, lw adr 0x100 (rs1=0xF0, imm=0x10), ack after 3 cycles, rdt 0x8000_00FF → o_wb_adr 0x100, sel 1111, o_rd reconstructs 0x8000_00FF over 32 cycles.
- W=4, lb at 0x103, rdt 0x8000_0000 → sel 1000, result 0xFFFF_FF80; lbu → 0x0000_0080.
- W=2, sh rs2=0x1234_ABCD at 0x202 → sel 1100, o_wb_dat 0xABCD_ABCD, o_wb_we 1.
- lw at 0x101 → o_misalign 1, o_wb_cyc never rises; i_trap=1 aligned → no cycle.
- i_wb_err and i_wb_ack together → o_err one cycle, data register unchanged; TIMEOUT=8, no ack → cyc drops after 8 cycles, o_err pulses.
- i_rst_n low while o_wb_cyc high, ack same cycle → cyc low next edge, all outputs at reset values.
